// File: rtl/game_timer_pkg.sv
// Shared state encodings, widths and the BCD helper for the game timer round sequencer.
package game_timer_pkg;

  localparam int unsigned SEC_W = 7;
  localparam int unsigned BCD_W = 8;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StCountdown = 3'd1,
    StPlay      = 3'd2,
    StWin       = 3'd3,
    StLose      = 3'd4
  } state_e;

  // Values above 99 keep only their last two decimal digits.
  function automatic logic [BCD_W-1:0] bin2bcd(input logic [SEC_W-1:0] bin);
    int unsigned v;
    v = 32'(bin) % 100;
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/game_timer_ctrl_if.sv
// Control/status bundle between the round sequencer and the game logic / sprite renderer.
interface game_timer_ctrl_if;
  import game_timer_pkg::*;

  logic             start;
  logic             pause;
  logic             player_win;
  logic [2:0]       state;
  logic [SEC_W-1:0] seconds_left;
  logic             tick_1hz;
  logic             show_countdown;
  logic             round_active;
  logic             game_over;
  logic [BCD_W-1:0] seconds_bcd;

  modport master (
    output start, pause, player_win,
    input  state, seconds_left, tick_1hz, show_countdown, round_active, game_over, seconds_bcd
  );

  modport slave (
    input  start, pause, player_win,
    output state, seconds_left, tick_1hz, show_countdown, round_active, game_over, seconds_bcd
  );

endinterface

// File: rtl/sec_prescaler.sv
// Divides clk down to a one-second strobe; tick is high in the cycle the count wraps.
module sec_prescaler #(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_HZ - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_timer_ctrl.sv
// Round sequencer: IDLE -> COUNTDOWN -> PLAY -> WIN/LOSE, with the 1 Hz prescaler and seconds counter.
// Optional GAME_TIMER_BCD_EN builds a registered binary-to-BCD copy of seconds_left.
module game_timer_ctrl
  import game_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned COUNT_SEC    = 8,
  parameter int unsigned ROUND_SEC    = 99,
  parameter int unsigned END_HOLD_SEC = 5
) (
  input logic              clk,
  input logic              resetn,
  game_timer_ctrl_if.slave bus
);

  localparam int unsigned HoldW = 4;

  state_e           state_q, state_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             start_q;
  logic             tick_q;
  logic             start_rise;
  logic             sec_tick;
  logic             presc_en;

  assign start_rise = bus.start & ~start_q;

  always_comb begin
    presc_en = 1'b0;
    case (state_q)
      StCountdown, StPlay: presc_en = ~bus.pause;
      StWin, StLose:       presc_en = 1'b1;
      default:             presc_en = 1'b0;
    endcase
  end

  // Any state change restarts the second, so each phase begins on a full count.
  sec_prescaler #(
    .CLK_HZ(CLK_HZ)
  ) u_sec_prescaler (
    .clk   (clk),
    .resetn(resetn),
    .enable(presc_en),
    .clear (state_d != state_q),
    .tick  (sec_tick)
  );

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if (start_rise) begin
          state_d = StCountdown;
          sec_d   = SEC_W'(COUNT_SEC);
        end
      end
      StCountdown: begin
        if (sec_tick) begin
          if (sec_q <= 7'd1) begin
            state_d = StPlay;
            sec_d   = SEC_W'(ROUND_SEC);
          end else begin
            sec_d = sec_q - 7'd1;
          end
        end
      end
      StPlay: begin
        // A win beats a simultaneous final tick and keeps the pre-tick value.
        if (bus.player_win) begin
          state_d = StWin;
          hold_d  = '0;
        end else if (sec_tick) begin
          if (sec_q <= 7'd1) begin
            state_d = StLose;
            sec_d   = '0;
            hold_d  = '0;
          end else begin
            sec_d = sec_q - 7'd1;
          end
        end
      end
      StWin, StLose: begin
        if (start_rise) begin
          state_d = StIdle;
        end else if (sec_tick) begin
          if (hold_q == HoldW'(END_HOLD_SEC - 1)) begin
            state_d = StIdle;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      sec_q   <= '0;
      hold_q  <= '0;
      start_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      hold_q  <= hold_d;
      start_q <= bus.start;
      tick_q  <= sec_tick;
    end
  end

  assign bus.state          = state_q;
  assign bus.seconds_left   = sec_q;
  assign bus.tick_1hz       = tick_q;
  assign bus.show_countdown = (state_q == StCountdown);
  assign bus.round_active   = (state_q == StPlay) & ~bus.pause;
  assign bus.game_over      = (state_q == StWin) | (state_q == StLose);

`ifdef GAME_TIMER_BCD_EN
  logic [BCD_W-1:0] bcd_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bcd_q <= '0;
    end else begin
      bcd_q <= bin2bcd(sec_q);
    end
  end

  assign bus.seconds_bcd = bcd_q;
`else
  assign bus.seconds_bcd = '0;
`endif

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl: directed vector table, hand sequences and a random run against a model.
module tb_game_timer_ctrl;

  localparam int CLK_HZ       = 10;
  localparam int COUNT_SEC    = 3;
  localparam int ROUND_SEC    = 5;
  localparam int END_HOLD_SEC = 2;

  // Model phases.
  localparam int MIdle = 0, MCount = 1, MPlay = 2, MWin = 3, MLose = 4;

  logic clk;
  logic resetn;

  game_timer_ctrl_if bus ();

  game_timer_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .COUNT_SEC   (COUNT_SEC),
    .ROUND_SEC   (ROUND_SEC),
    .END_HOLD_SEC(END_HOLD_SEC)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int m_state, m_sec, m_elapsed, m_hold, m_tick, m_bcd, m_start_prev;

  typedef struct {
    int start;
    int pause;
    int win;
    int cycles;
    int st;
    int sec;
    int show;
    int act;
    int over;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_bcd(input int v);
`ifdef GAME_TIMER_BCD_EN
    return ((v % 100) / 10) * 16 + (v % 10);
`else
    return 0 * v;
`endif
  endfunction

  task automatic model_reset();
    m_state = MIdle; m_sec = 0; m_elapsed = 0; m_hold = 0;
    m_tick = 0; m_bcd = 0; m_start_prev = 0;
  endtask

  // One clock of the round rules, evaluated on the inputs present at the edge.
  task automatic model_clock();
    int nxt, nsec, rise, run, second;
    rise = (bus.start && m_start_prev == 0) ? 1 : 0;
    if (m_state == MCount || m_state == MPlay) run = bus.pause ? 0 : 1;
    else run = (m_state == MWin || m_state == MLose) ? 1 : 0;
    second = (run != 0 && m_elapsed == CLK_HZ - 1) ? 1 : 0;
    nxt = m_state;
    nsec = m_sec;
    case (m_state)
      MIdle: if (rise != 0) begin nxt = MCount; nsec = COUNT_SEC; end
      MCount: if (second != 0) begin
        if (m_sec == 1) begin nxt = MPlay; nsec = ROUND_SEC; end
        else nsec = m_sec - 1;
      end
      MPlay: if (bus.player_win) begin
        nxt = MWin; m_hold = 0;
      end else if (second != 0) begin
        if (m_sec == 1) begin nxt = MLose; nsec = 0; m_hold = 0; end
        else nsec = m_sec - 1;
      end
      default: if (rise != 0) nxt = MIdle;
        else if (second != 0) begin
          m_hold = m_hold + 1;
          if (m_hold == END_HOLD_SEC) nxt = MIdle;
        end
    endcase
    m_bcd = exp_bcd(m_sec);
    if (nxt != m_state || second != 0) m_elapsed = 0;
    else if (run != 0) m_elapsed = m_elapsed + 1;
    m_tick = second;
    m_state = nxt;
    m_sec = nsec;
    m_start_prev = bus.start ? 1 : 0;
  endtask

  task automatic compare_model();
    chk("model state", int'(bus.state), m_state);
    chk("model seconds_left", int'(bus.seconds_left), m_sec);
    chk("model tick_1hz", int'(bus.tick_1hz), m_tick);
    chk("model show_countdown", int'(bus.show_countdown), (m_state == MCount) ? 1 : 0);
    chk("model round_active", int'(bus.round_active),
        (m_state == MPlay && !bus.pause) ? 1 : 0);
    chk("model game_over", int'(bus.game_over), (m_state == MWin || m_state == MLose) ? 1 : 0);
    chk("model seconds_bcd", int'(bus.seconds_bcd), m_bcd);
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic cycle(input int s, input int p, input int w);
    bus.start = (s != 0);
    bus.pause = (p != 0);
    bus.player_win = (w != 0);
    @(posedge clk);
    model_clock();
    @(negedge clk);
    compare_model();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " state"}, int'(bus.state), 0);
    chk({tag, " seconds_left"}, int'(bus.seconds_left), 0);
    chk({tag, " tick_1hz"}, int'(bus.tick_1hz), 0);
    chk({tag, " show_countdown"}, int'(bus.show_countdown), 0);
    chk({tag, " round_active"}, int'(bus.round_active), 0);
    chk({tag, " game_over"}, int'(bus.game_over), 0);
    chk({tag, " seconds_bcd"}, int'(bus.seconds_bcd), 0);
  endtask

  // Asserts reset between edges and checks that outputs clear without a clock.
  task automatic do_reset();
    #2;
    resetn = 1'b0;
    #1;
    check_reset_values("async reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int s, p, w;
    resetn = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.player_win = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    resetn = 1'b1;

    //          start pause win cycles state sec show act over
    tbl.push_back('{1, 0, 0,  1, 1, 3, 1, 0, 0});   // start edge -> countdown 3
    tbl.push_back('{0, 0, 0,  9, 1, 3, 1, 0, 0});
    tbl.push_back('{0, 0, 0,  1, 1, 2, 1, 0, 0});   // 3 held exactly 10 cycles
    tbl.push_back('{0, 0, 0, 10, 1, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 0,  9, 1, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 0,  1, 2, 5, 0, 1, 0});   // play starts at ROUND_SEC
    tbl.push_back('{0, 0, 0, 50, 4, 0, 0, 0, 1});   // timeout -> lose
    tbl.push_back('{0, 0, 0, 19, 4, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0,  1, 0, 0, 0, 0, 0});   // hold of 2 s back to idle
    tbl.push_back('{1, 0, 0,  1, 1, 3, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 30, 2, 5, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 10, 2, 4, 0, 1, 0});
    tbl.push_back('{0, 0, 1,  1, 3, 4, 0, 0, 1});   // win freezes 4
    tbl.push_back('{0, 0, 0, 20, 0, 4, 0, 0, 0});
    tbl.push_back('{1, 0, 0,  1, 1, 3, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 30, 2, 5, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 40, 2, 1, 0, 1, 0});
    tbl.push_back('{0, 0, 0,  9, 2, 1, 0, 1, 0});
    tbl.push_back('{0, 0, 1,  1, 3, 1, 0, 0, 1});   // win with final tick keeps 1
    tbl.push_back('{1, 0, 0,  1, 0, 1, 0, 0, 0});   // start skips the hold
    tbl.push_back('{0, 0, 0,  1, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 1, 1,  3, 0, 1, 0, 0, 0});   // pause/win ignored in idle
    tbl.push_back('{1, 0, 0,  1, 1, 3, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 30, 2, 5, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 24, 2, 3, 0, 1, 0});
    tbl.push_back('{0, 1, 0, 25, 2, 3, 0, 0, 0});   // paused: value holds
    tbl.push_back('{0, 0, 0,  5, 2, 3, 0, 1, 0});   // remaining 5 of 10 cycles
    tbl.push_back('{0, 0, 0,  1, 2, 2, 0, 1, 0});

    foreach (tbl[i]) begin
      repeat (tbl[i].cycles) cycle(tbl[i].start, tbl[i].pause, tbl[i].win);
      chk($sformatf("tbl[%0d] state", i), int'(bus.state), tbl[i].st);
      chk($sformatf("tbl[%0d] seconds_left", i), int'(bus.seconds_left), tbl[i].sec);
      chk($sformatf("tbl[%0d] show_countdown", i), int'(bus.show_countdown), tbl[i].show);
      chk($sformatf("tbl[%0d] round_active", i), int'(bus.round_active), tbl[i].act);
      chk($sformatf("tbl[%0d] game_over", i), int'(bus.game_over), tbl[i].over);
    end

    // Reset mid-play, then a fresh round to see the BCD value one cycle after 5 appears.
    do_reset();
    cycle(1, 0, 0);
    repeat (30) cycle(0, 0, 0);
    chk("after reset seconds_left", int'(bus.seconds_left), 5);
    cycle(0, 0, 0);
`ifdef GAME_TIMER_BCD_EN
    chk("bcd of 5", int'(bus.seconds_bcd), 8'h05);
`else
    chk("bcd tied off", int'(bus.seconds_bcd), 0);
`endif

    s = 0; p = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 9) == 0) s = 1 - s;
      if ($urandom_range(0, 19) == 0) p = 1 - p;
      w = ($urandom_range(0, 29) == 0) ? 1 : 0;
      if ($urandom_range(0, 999) == 0) do_reset();
      cycle(s, p, w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
